muldiv_sched: RTL
=================

Name: muldiv_sched

Overview:
- Sequencing controller for the multi-cycle HI/LO operations issued from the EX stage: MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV and DIVU.
- Owns a registered 64-bit product stage and the accumulate step.
- Drives the start/annul handshake of the shared iterative divider.
- Produces the EX stall request and a single HI/LO write that is held until the pipeline advances, so an op never executes twice under an external stall.

Parameters:
DATA_W, 32, operand width; HI/LO path is 2*DATA_W.
DIV_TIMEOUT, 64, maximum cycles in DIV_WAIT before the divide is abandoned.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
op_valid_i  in  1  EX holds a muldiv op; held high while busy_o=1
op_i  in  3  0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 DIV, 7 DIVU
rs_i  in  DATA_W  operand 1 / dividend
rt_i  in  DATA_W  operand 2 / divisor
hilo_i  in  2*DATA_W  current {HI,LO}, already forwarded
advance_i  in  1  EX/MEM register captures EX this cycle
annul_i  in  1  flush of the EX instruction
busy_o  out  1  stall request to ctrl
done_o  out  1  one-cycle pulse on the first DONE cycle
hilo_we_o  out  1  HI and LO write enable
hilo_o  out  2*DATA_W  {HI,LO} write data
div_start_o  out  1  divider start, level
div_annul_o  out  1  divider cancel, one-cycle pulse
div_signed_o  out  1  signed divide
div_op1_o  out  DATA_W  latched dividend
div_op2_o  out  DATA_W  latched divisor
div_ready_i  in  1  divider result valid
div_result_i  in  2*DATA_W  {remainder, quotient}
timeout_o  out  1  sticky flag: a divide timed out

Behaviour:
- Reset (sync, highest priority, valid mid-operation):
  - state IDLE.
  - busy_o, done_o, hilo_we_o, div_start_o, div_annul_o, timeout_o and div_signed_o all 0.
  - hilo_o, div_op1_o, div_op2_o all 0; prod_q and cycle counter cleared.
- States: IDLE, ACC, DIV_WAIT, DONE.
- busy_o, combinational:
  - IDLE: busy_o = op_valid_i.
  - ACC and DIV_WAIT: busy_o = 1.
  - DONE: busy_o = 0.
  - annul_i=1 forces busy_o = 0.
- IDLE, op_valid_i=1 and annul_i=0 (accept edge):
  - prod_q <= rs_i*rt_i as 2*DATA_W bits: signed for ops 0/2/4, unsigned for 1/3/5.
  - Ops 0/1: hilo_o <= product; go to DONE. Busy 1 cycle.
  - Ops 2..5: go to ACC. Busy 2 cycles.
  - Ops 6/7 with rt_i=0: go to DONE with the no-write flag set (result undefined, HI/LO unchanged).
  - Ops 6/7 with rt_i≠0: latch div_op1_o/div_op2_o; div_signed_o = (op_i==6); go to DIV_WAIT; clear the counter.
- ACC (one cycle):
  - hilo_o <= hilo_i + prod_q for MADD/MADDU, hilo_i - prod_q for MSUB/MSUBU, modulo 2^(2*DATA_W).
  - hilo_i is sampled in this cycle; go to DONE.
- DIV_WAIT:
  - div_start_o = 1 while div_ready_i=0.
  - On div_ready_i=1: hilo_o <= div_result_i, div_start_o = 0 that cycle, go to DONE.
  - Counter increments each cycle. When it reaches DIV_TIMEOUT without ready: div_annul_o pulses, timeout_o <= 1, go to DONE with no write.
- DONE:
  - done_o = 1 on the first cycle only.
  - hilo_we_o = 1 every DONE cycle unless the no-write flag is set; hilo_o held stable.
  - Stays in DONE until advance_i=1, then goes to IDLE.
  - op_valid_i remaining high while in DONE never restarts the op.
- annul_i in any state:
  - Next state IDLE; no HI/LO write.
  - From DIV_WAIT, div_annul_o = 1 for that cycle and div_start_o = 0.
  - annul_i takes priority over div_ready_i and over accept.
- advance_i outside DONE is ignored.
- op_i is sampled only at the accept edge; changes afterwards are ignored.

Test Plan:
- MULT rs=0xFFFFFFFE, rt=3: busy_o 1 cycle, DONE next; hilo_o=0xFFFFFFFF_FFFFFFFA; MULTU same operands gives 0x00000002_FFFFFFFA.
- MADD rs=2, rt=3, hilo_i=0x00000000_FFFFFFFF: busy_o 2 cycles, hilo_o=0x00000001_00000005. MSUBU rs=1, rt=1, hilo_i=0 gives 0xFFFFFFFF_FFFFFFFF.
- DIV rs=-7, rt=2, divider ready after 34 cycles with result {0xFFFFFFFF, 0xFFFFFFFD}: div_start_o high 34 cycles, div_signed_o=1, busy_o drops in DONE, hilo_we_o=1 with that value.
- DONE held with advance_i=0 for 5 cycles and op_valid_i=1: done_o pulses once; hilo_we_o stays 1; no second accept; IDLE after advance_i=1.
- annul_i during DIV_WAIT cycle 10: div_annul_o pulses 1 cycle; IDLE next; no write. Also rst asserted in ACC: all outputs 0 next cycle.
- DIVU rt=0: DONE after 1 cycle, hilo_we_o=0. Divider never ready for DIV_TIMEOUT=64 cycles: div_annul_o pulse, timeout_o=1 sticky until rst.

Source files
------------

// File: rtl/muldiv_sched.sv
// muldiv_sched: sequences MULT/MADD/MSUB/DIV ops from EX, drives the shared divider and a held HI/LO write.
module muldiv_sched #(
  parameter int DATA_W      = 32,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid_i,
  input  logic [2:0]          op_i,
  input  logic [DATA_W-1:0]   rs_i,
  input  logic [DATA_W-1:0]   rt_i,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic                advance_i,
  input  logic                annul_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                hilo_we_o,
  output logic [2*DATA_W-1:0] hilo_o,
  output logic                div_start_o,
  output logic                div_annul_o,
  output logic                div_signed_o,
  output logic [DATA_W-1:0]   div_op1_o,
  output logic [DATA_W-1:0]   div_op2_o,
  input  logic                div_ready_i,
  input  logic [2*DATA_W-1:0] div_result_i,
  output logic                timeout_o
);
  localparam int HW = 2 * DATA_W;
  localparam int CW = $clog2(DIV_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ACC, DIV_WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [HW-1:0] prod_q, prod_d, hilo_q, hilo_d, ext_rs, ext_rt, mul;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sub_q, sub_d, sgn_q, sgn_d, tmo_q, tmo_d, nowr_q, nowr_d, first_q, first_d;
  logic tmo_hit;
  // Odd opcodes are the unsigned variants, so bit 0 selects zero extension.
  assign ext_rs  = op_i[0] ? {{DATA_W{1'b0}}, rs_i} : {{DATA_W{rs_i[DATA_W-1]}}, rs_i};
  assign ext_rt  = op_i[0] ? {{DATA_W{1'b0}}, rt_i} : {{DATA_W{rt_i[DATA_W-1]}}, rt_i};
  assign mul     = ext_rs * ext_rt;
  assign tmo_hit = state_q == DIV_WAIT && !div_ready_i && cnt_q == CW'(DIV_TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    hilo_d  = hilo_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    sgn_d   = sgn_q;
    tmo_d   = tmo_q;
    nowr_d  = nowr_q;
    if (annul_i) state_d = IDLE;
    else case (state_q)
      IDLE: if (op_valid_i) begin
        prod_d = mul;
        sub_d  = op_i[2];
        nowr_d = 1'b0;
        cnt_d  = '0;
        if (op_i[2:1] == 2'b11) begin
          if (rt_i == '0) begin
            nowr_d  = 1'b1;
            state_d = DONE;
          end else begin
            op1_d   = rs_i;
            op2_d   = rt_i;
            sgn_d   = !op_i[0];
            state_d = DIV_WAIT;
          end
        end else if (op_i[2:1] == 2'b00) begin
          hilo_d  = mul;
          state_d = DONE;
        end else state_d = ACC;
      end
      ACC: begin
        hilo_d  = sub_q ? hilo_i - prod_q : hilo_i + prod_q;
        state_d = DONE;
      end
      DIV_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (div_ready_i) begin
          hilo_d  = div_result_i;
          state_d = DONE;
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          nowr_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: if (advance_i) state_d = IDLE;
    endcase
    first_d = state_d == DONE && state_q != DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prod_q  <= '0;
      hilo_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      sgn_q   <= 1'b0;
      tmo_q   <= 1'b0;
      nowr_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      hilo_q  <= hilo_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      sgn_q   <= sgn_d;
      tmo_q   <= tmo_d;
      nowr_q  <= nowr_d;
      first_q <= first_d;
    end
  end
  assign busy_o       = !annul_i && (state_q == IDLE ? op_valid_i : state_q != DONE);
  assign done_o       = state_q == DONE && first_q;
  assign hilo_we_o    = state_q == DONE && !nowr_q && !annul_i;
  assign hilo_o       = hilo_q;
  assign div_start_o  = state_q == DIV_WAIT && !div_ready_i && !annul_i && !tmo_hit;
  assign div_annul_o  = state_q == DIV_WAIT && (annul_i || tmo_hit);
  assign div_signed_o = sgn_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign timeout_o    = tmo_q;
endmodule
